// File: rtl/io_step_sequencer.sv
// Stalls the PC for IN (wait for flag edge, then one-cycle write), OUT (timed display strobe) and HLT (freeze until reset).
// Optional DEBOUNCE_EN macro adds a DEB_CYCLES stability filter on the synchronized flag.
module io_step_sequencer #(
  parameter logic [5:0]  OP_IN    = 6'b011110,
  parameter logic [5:0]  OP_OUT   = 6'b011111,
  parameter logic [5:0]  OP_HLT   = 6'b111111,
  parameter int unsigned OUT_HOLD = 4
`ifdef DEBOUNCE_EN
  ,
  parameter int unsigned DEB_CYCLES = 8
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       instr_valid,
  input  logic       flag_in,
  output logic       halt_pc,
  output logic       in_we,
  output logic       fout,
  output logic       halted,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    WAIT_IN = 3'd1,
    CAPTURE = 3'd2,
    SHOW    = 3'd3,
    HALTED  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic       halt_pc_q, halt_pc_d, in_we_q, in_we_d, fout_q, fout_d, halted_q, halted_d;
  logic       flag_lvl, flag_rise;

`ifdef DEBOUNCE_EN
  logic       deb_q, deb_d;
  logic [7:0] stab_q, stab_d;

  // The level flips only after DEB_CYCLES consecutive cycles of disagreement.
  always_comb begin
    deb_d  = deb_q;
    stab_d = '0;
    if (sync2_q != deb_q) begin
      if (stab_q == 8'(DEB_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        stab_d = stab_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_q  <= 1'b0;
      stab_q <= '0;
    end else begin
      deb_q  <= deb_d;
      stab_q <= stab_d;
    end
  end

  assign flag_lvl = deb_q;
`else
  assign flag_lvl = sync2_q;
`endif

  always_comb begin
    sync1_d = flag_in;
    sync2_d = sync1_q;
    edge_d  = flag_lvl;
  end

  assign flag_rise = flag_lvl & ~edge_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (instr_valid) begin
          if (opcode == OP_IN) begin
            state_d = WAIT_IN;
          end else if (opcode == OP_OUT) begin
            state_d = SHOW;
            cnt_d   = 8'(OUT_HOLD - 1);
          end else if (opcode == OP_HLT) begin
            state_d = HALTED;
          end
        end
      end
      WAIT_IN: if (flag_rise) state_d = CAPTURE;
      CAPTURE: state_d = RUN;
      SHOW: begin
        if (cnt_q == 8'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the state itself.
  always_comb begin
    halt_pc_d = (state_d != RUN) && (state_d != CAPTURE);
    in_we_d   = (state_d == CAPTURE);
    fout_d    = (state_d == SHOW);
    halted_d  = (state_d == HALTED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halt_pc_q <= 1'b0;
      in_we_q   <= 1'b0;
      fout_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      halt_pc_q <= halt_pc_d;
      in_we_q   <= in_we_d;
      fout_q    <= fout_d;
      halted_q  <= halted_d;
    end
  end

  assign halt_pc   = halt_pc_q;
  assign in_we     = in_we_q;
  assign fout      = fout_q;
  assign halted    = halted_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_io_step_sequencer.sv
// Randomized directed bench for io_step_sequencer; expectations come from per-instruction timing rules.
module tb_io_step_sequencer;
  localparam logic [5:0] OP_IN  = 6'b011110;
  localparam logic [5:0] OP_OUT = 6'b011111;
  localparam logic [5:0] OP_HLT = 6'b111111;
  localparam int OUT_HOLD = 4;
`ifdef DEBOUNCE_EN
  localparam int DEB = 8;
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       instr_valid = 1'b0;
  logic       flag_in = 1'b0;
  logic       halt_pc, in_we, fout, halted;
  logic [2:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  io_step_sequencer #(.OUT_HOLD(OUT_HOLD)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .flag_in    (flag_in),
    .halt_pc    (halt_pc),
    .in_we      (in_we),
    .fout       (fout),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input logic hp, input logic we,
                          input logic fo, input logic ht);
    chk({tag, ".state"},   8'(state_dbg), 8'(st));
    chk({tag, ".halt_pc"}, 8'(halt_pc),   8'(hp));
    chk({tag, ".in_we"},   8'(in_we),     8'(we));
    chk({tag, ".fout"},    8'(fout),      8'(fo));
    chk({tag, ".halted"},  8'(halted),    8'(ht));
  endtask

  function automatic logic [5:0] plain_op();
    logic [5:0] op;
    op = 6'($urandom_range(0, 63));
    while (op == OP_IN || op == OP_OUT || op == OP_HLT) op = 6'($urandom_range(0, 63));
    return op;
  endfunction

  task automatic issue(input logic [5:0] op);
    instr_valid = 1'b1;
    opcode      = op;
    step();
    instr_valid = 1'b0;
    opcode      = plain_op();
  endtask

  // Flag rises now; capture must appear exactly LAT edges later with the wait held until then.
  task automatic expect_capture(input string tag);
    flag_in = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      step();
      chk_outs({tag, ".wait"}, 1, 1, 0, 0, 0);
    end
    step();
    chk_outs({tag, ".capture"}, 2, 0, 1, 0, 0);
    step();
    chk_outs({tag, ".after"}, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk_outs(tag, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int kind, w;
    #3;
    chk_outs("reset", 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    step();
    chk_outs("release", 0, 0, 0, 0, 0);

    issue(6'b000001);
    chk_outs("plain_op", 0, 0, 0, 0, 0);
    opcode = OP_IN;
    step();
    chk_outs("in_no_valid", 0, 0, 0, 0, 0);

    // IN with a long low wait before the flag rises
    issue(OP_IN);
    for (int i = 0; i < 20; i++) begin
      chk_outs("in20.wait", 1, 1, 0, 0, 0);
      step();
    end
    expect_capture("in20");
    flag_in = 1'b0;
    idle_run("in20.settle", SETTLE);

    // Flag already high on entry must not complete the wait
    flag_in = 1'b1;
    idle_run("prehigh.run", SETTLE);
    issue(OP_IN);
    for (int i = 0; i < 15; i++) begin
      chk_outs("prehigh.wait", 1, 1, 0, 0, 0);
      step();
    end
    flag_in = 1'b0;
    for (int i = 0; i < SETTLE; i++) begin
      step();
      chk_outs("prehigh.low", 1, 1, 0, 0, 0);
    end
    expect_capture("prehigh");
    flag_in = 1'b0;
    idle_run("prehigh.settle", SETTLE);

`ifdef DEBOUNCE_EN
    issue(OP_IN);
    flag_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    flag_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_outs("glitch.wait", 1, 1, 0, 0, 0);
    end
    expect_capture("pulse12");
    for (int i = 0; i < 12 - LAT - 1; i++) step();
    flag_in = 1'b0;
    idle_run("pulse12.settle", SETTLE);
`endif

    // Randomized mix of plain, IN and OUT instructions
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        issue(plain_op());
        chk_outs("rnd.plain", 0, 0, 0, 0, 0);
        idle_run("rnd.plain_idle", $urandom_range(0, 3));
      end else if (kind == 1) begin
        issue(OP_IN);
        w = $urandom_range(0, 20);
        for (int i = 0; i < w; i++) begin
          chk_outs("rnd.in_wait", 1, 1, 0, 0, 0);
          instr_valid = $urandom_range(0, 1);
          opcode      = ($urandom_range(0, 1) != 0) ? OP_OUT : OP_HLT;
          step();
        end
        instr_valid = 1'b0;
        chk_outs("rnd.in_wait", 1, 1, 0, 0, 0);
        expect_capture("rnd.in");
        flag_in = 1'b0;
        idle_run("rnd.in_settle", SETTLE);
      end else begin
        issue(OP_OUT);
        for (int i = 0; i < OUT_HOLD; i++) begin
          chk_outs("rnd.show", 3, 1, 0, 1, 0);
          step();
        end
        chk_outs("rnd.show_done", 0, 0, 0, 0, 0);
      end
    end

    // Reset during WAIT_IN
    issue(OP_IN);
    for (int i = 0; i < 3; i++) step();
    chk_outs("rst_wait.pre", 1, 1, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk_outs("rst_wait", 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    step();
    chk_outs("rst_wait.release", 0, 0, 0, 0, 0);

    // Reset during SHOW with two cycles left on the counter
    issue(OP_OUT);
    step();
    chk_outs("rst_show.pre", 3, 1, 0, 1, 0);
    reset = 1'b0;
    #1;
    chk_outs("rst_show", 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    step();
    chk_outs("rst_show.release", 0, 0, 0, 0, 0);

    // HLT persists through further instructions and flag edges until reset
    issue(OP_HLT);
    chk_outs("hlt", 4, 1, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      instr_valid = $urandom_range(0, 1);
      opcode      = ($urandom_range(0, 1) != 0) ? OP_IN : OP_OUT;
      flag_in     = $urandom_range(0, 1);
      step();
      chk_outs("hlt.hold", 4, 1, 0, 0, 1);
    end
    instr_valid = 1'b0;
    flag_in     = 1'b0;
    reset = 1'b0;
    #1;
    chk_outs("hlt.reset", 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    idle_run("hlt.release", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
